// File: rtl/cardinal_nic.sv
// Network interface between one processing element and a mesh router PE port.
// Single-entry output and input channel buffers, VC-polarity-aware injection.
module cardinal_nic #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_so,
    output logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_ri,
    input  logic              net_si,
    input  logic [DATA_W-1:0] net_di,
    input  logic              net_polarity
);

    logic [DATA_W-1:0] ocb;
    logic              ocb_full;
    logic [DATA_W-1:0] icb;
    logic              icb_full;

    logic pe_wr;
    logic pe_rd;
    logic send;
    logic load;

    assign pe_wr = nicEn & nicWrEn;
    assign pe_rd = nicEn & ~nicWrEn;

    // The packet VC bit must be opposite to the router's current polarity.
    assign send = ocb_full & net_ri & (ocb[DATA_W-1] == ~net_polarity) & ~reset;
    assign load = net_si & net_ro;

    assign net_so = send;
    assign net_do = ocb;
    assign net_ro = ~icb_full & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocb      <= '0;
            ocb_full <= 1'b0;
            icb      <= '0;
            icb_full <= 1'b0;
        end else begin
            // A write can only land in an empty OCB, so it never races a send.
            if (pe_wr && addr == 2'b10 && !ocb_full) begin
                ocb      <= d_in;
                ocb_full <= 1'b1;
            end else if (send) begin
                ocb_full <= 1'b0;
            end

            // A router load beats a same-edge PE consume of an empty ICB.
            if (load) begin
                icb      <= net_di;
                icb_full <= 1'b1;
            end else if (pe_rd && addr == 2'b00) begin
                icb_full <= 1'b0;
            end
        end
    end

    always_comb begin
        d_out = '0;
        if (pe_rd) begin
            case (addr)
                2'b00:   d_out = icb;
                2'b01:   d_out = {{(DATA_W-1){1'b0}}, icb_full};
                2'b11:   d_out = {{(DATA_W-1){1'b0}}, ocb_full};
                default: d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed vector table plus reset sequences.
module tb_cardinal_nic;

    localparam int unsigned DATA_W = 64;
    localparam logic [63:0] PKT_A = 64'h8000_0000_0000_00AB;

    logic              clk;
    logic              reset;
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nicEn;
    logic              nicWrEn;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_ri;
    logic              net_si;
    logic [DATA_W-1:0] net_di;
    logic              net_polarity;

    int pass_cnt;
    int total_cnt;

    cardinal_nic #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .d_in        (d_in),
        .d_out       (d_out),
        .nicEn       (nicEn),
        .nicWrEn     (nicWrEn),
        .net_so      (net_so),
        .net_ro      (net_ro),
        .net_do      (net_do),
        .net_ri      (net_ri),
        .net_si      (net_si),
        .net_di      (net_di),
        .net_polarity(net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        en;
        logic        wr;
        logic [63:0] din;
        logic        ri;
        logic        si;
        logic [63:0] di;
        logic        pol;
        logic [63:0] edout;
        logic        eso;
        logic        ero;
        logic [63:0] edo;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [1:0] a, input logic en, input logic wr,
                                input logic [63:0] din, input logic ri, input logic si,
                                input logic [63:0] di, input logic pol,
                                input logic [63:0] edout, input logic eso,
                                input logic ero, input logic [63:0] edo);
        vec_t v;
        v.addr = a; v.en = en; v.wr = wr; v.din = din; v.ri = ri; v.si = si;
        v.di = di; v.pol = pol; v.edout = edout; v.eso = eso; v.ero = ero; v.edo = edo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic en, input logic wr,
                         input logic [63:0] din, input logic ri, input logic si,
                         input logic [63:0] di, input logic pol);
        addr = a; nicEn = en; nicWrEn = wr; d_in = din;
        net_ri = ri; net_si = si; net_di = di; net_polarity = pol;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);

        // Outputs held quiet during reset
        #2;
        chk("rst_so", {63'h0, net_so}, 64'h0);
        chk("rst_ro", {63'h0, net_ro}, 64'h0);
        chk("rst_dout", d_out, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        //          addr  en wr din         ri si di          pol  dout        so ro do
        vq.push_back(mk(2'b01, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h0));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h0));
        vq.push_back(mk(2'b10, 1, 1, PKT_A,       1, 0, 64'h0,      1, 64'h0,      0, 1, 64'h0));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       1, 0, 64'h0,      1, 64'h1,      0, 1, PKT_A));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       1, 0, 64'h0,      0, 64'h1,      1, 1, PKT_A));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       1, 0, 64'h0,      0, 64'h0,      0, 1, PKT_A));
        // Full OCB with router not ready: second write dropped, first sent once
        vq.push_back(mk(2'b10, 1, 1, 64'h2,       0, 0, 64'h0,      1, 64'h0,      0, 1, PKT_A));
        vq.push_back(mk(2'b10, 1, 1, 64'h1,       0, 0, 64'h0,      1, 64'h0,      0, 1, 64'h2));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       0, 0, 64'h0,      1, 64'h1,      0, 1, 64'h2));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       1, 0, 64'h0,      0, 64'h1,      0, 1, 64'h2));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       1, 0, 64'h0,      1, 64'h1,      1, 1, 64'h2));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       1, 0, 64'h0,      1, 64'h0,      0, 1, 64'h2));
        // Write on the same edge the OCB drains is still dropped
        vq.push_back(mk(2'b10, 1, 1, 64'h3,       0, 0, 64'h0,      1, 64'h0,      0, 1, 64'h2));
        vq.push_back(mk(2'b10, 1, 1, 64'h7,       1, 0, 64'h0,      1, 64'h0,      1, 1, 64'h3));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       0, 0, 64'h0,      1, 64'h0,      0, 1, 64'h3));
        // Ejection, protocol violation ignored, consume
        vq.push_back(mk(2'b01, 1, 0, 64'h0,       0, 1, 64'h1234,   0, 64'h0,      0, 1, 64'h3));
        vq.push_back(mk(2'b01, 1, 0, 64'h0,       0, 1, 64'h5555,   0, 64'h1,      0, 0, 64'h3));
        vq.push_back(mk(2'b00, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h1234,   0, 0, 64'h3));
        vq.push_back(mk(2'b01, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h3));
        // Consume of empty ICB races a load: load wins
        vq.push_back(mk(2'b00, 1, 0, 64'h0,       0, 1, 64'hABCD,   0, 64'h1234,   0, 1, 64'h3));
        vq.push_back(mk(2'b01, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h1,      0, 0, 64'h3));
        vq.push_back(mk(2'b00, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'hABCD,   0, 0, 64'h3));
        // Read of addr 10, disabled access, ignored writes
        vq.push_back(mk(2'b10, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h3));
        vq.push_back(mk(2'b00, 0, 0, 64'h0,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h3));
        vq.push_back(mk(2'b00, 1, 1, 64'hFFFF,    0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h3));
        vq.push_back(mk(2'b00, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'hABCD,   0, 1, 64'h3));
        vq.push_back(mk(2'b11, 1, 1, 64'h9,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h3));
        vq.push_back(mk(2'b11, 1, 0, 64'h0,       0, 0, 64'h0,      0, 64'h0,      0, 1, 64'h3));

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].addr, vq[i].en, vq[i].wr, vq[i].din, vq[i].ri, vq[i].si,
                  vq[i].di, vq[i].pol);
            #1;
            chk($sformatf("v%0d_dout", i), d_out, vq[i].edout);
            chk($sformatf("v%0d_so", i), {63'h0, net_so}, {63'h0, vq[i].eso});
            chk($sformatf("v%0d_ro", i), {63'h0, net_ro}, {63'h0, vq[i].ero});
            chk($sformatf("v%0d_do", i), net_do, vq[i].edo);
        end

        // Reset with both buffers full and a send pending
        @(negedge clk);
        drive(2'b10, 1'b1, 1'b1, PKT_A, 1'b0, 1'b1, 64'h77, 1'b0);
        @(negedge clk);
        drive(2'b01, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        #1;
        chk("pre_rst_icb_full", d_out, 64'h1);
        chk("pre_rst_ro", {63'h0, net_ro}, 64'h0);
        @(negedge clk);
        drive(2'b11, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0);
        #1;
        chk("pre_rst_ocb_full", d_out, 64'h1);
        chk("pre_rst_so", {63'h0, net_so}, 64'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_so", {63'h0, net_so}, 64'h0);
        chk("mid_rst_ro", {63'h0, net_ro}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        addr = 2'b01;
        #1;
        chk("post_rst_icb_stat", d_out, 64'h0);
        chk("post_rst_ro", {63'h0, net_ro}, 64'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            addr = 2'b11;
            #1;
            chk($sformatf("post_rst_so%0d", k), {63'h0, net_so}, 64'h0);
            chk($sformatf("post_rst_ocb_stat%0d", k), d_out, 64'h0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
Network interface controller that sits between one processing element (PE) and the PE port of one mesh router node.
- Exposes a 2-bit register map to the PE: input buffer, input status, output buffer, output status.
- Injects PE packets into the router and ejects router packets to the PE.
- Uses a single-entry output channel buffer (OCB) and a single-entry input channel buffer (ICB), each with a full flag.
- Injection obeys the router's ready signal and its even/odd virtual-channel (VC) polarity.

Parameters:
DATA_W, 64, packet/register width; bit DATA_W-1 is the packet VC bit.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
addr  input  2  PE register select: 00 ICB, 01 ICB status, 10 OCB, 11 OCB status
d_in  input  DATA_W  PE write data
d_out  output  DATA_W  PE read data (combinational)
nicEn  input  1  PE access enable
nicWrEn  input  1  1 = write, 0 = read (valid only with nicEn)
net_so  output  1  send-out to router PE input (router pe_si)
net_ro  output  1  NIC ready to accept from router (router pe_ro)
net_do  output  DATA_W  packet to router (router pe_di)
net_ri  input  1  router ready to accept from NIC (router pe_ri)
net_si  input  1  router sending to NIC (router pe_so)
net_di  input  DATA_W  packet from router (router pe_do)
net_polarity  input  1  router polarity (router pe_polarity)

Behaviour:
- State: ocb[DATA_W], ocb_full, icb[DATA_W], icb_full; all registered with async reset.
- Reset: all state = 0. While reset = 1, net_so = 0 and net_ro = 0. d_out = 0 unless a read is presented.
- Reset mid-operation: any buffered packet is discarded immediately; no partial send is completed.
- PE write, addr 10 (nicEn & nicWrEn):
  - If ocb_full = 0 at the edge: ocb <= d_in, ocb_full <= 1.
  - If ocb_full = 1: the write is silently dropped, even if the OCB drains on the same edge.
- PE writes to addr 00, 01 or 11 are ignored.
- PE read (nicEn & ~nicWrEn), d_out combinational:
  - addr 00: d_out = icb; at the edge icb_full <= 0 (read consumes; reading an empty ICB returns stale data and has no effect).
  - addr 01: d_out = {zeros, icb_full}.
  - addr 11: d_out = {zeros, ocb_full}.
  - addr 10: d_out = 0.
- d_out = 0 when nicEn = 0 or on any write.
- Injection (combinational outputs):
  - send = ocb_full & net_ri & (ocb[DATA_W-1] == ~net_polarity) & ~reset.
  - net_so = send; net_do = ocb at all times.
  - On an edge with send = 1: ocb_full <= 0. Latency is 0 cycles from the enabling condition; the router captures on the same edge.
  - If the VC bit does not match, the packet waits and is sent in the next cycle of opposite polarity while net_ri = 1.
- Ejection:
  - net_ro = ~icb_full & ~reset.
  - On an edge with net_si & net_ro: icb <= net_di, icb_full <= 1.
  - net_si while icb_full = 1 is a protocol violation: the packet is ignored and icb is unchanged.
  - A PE read of addr 00 on the same edge the ICB is empty (net_ro = 1) and net_si = 1: the load wins and icb_full ends at 1.
- Injection and ejection paths are independent; both may complete on the same edge.

Test Plan:
- Reset, then idle: net_so = 0, net_ro = 1, addr 01 and addr 11 reads return 0.
- Write 64'h8000_0000_0000_00AB to addr 10 with net_ri = 1:
  - net_so rises only in a cycle with net_polarity = 0, net_do = that value.
  - addr 11 reads 0 on the next cycle.
- With ocb_full = 1 and net_ri = 0, write 64'h1: dropped. Raise net_ri with a matching polarity and the original packet is sent exactly once.
- Router drives net_si = 1, net_di = 64'h1234:
  - addr 01 reads 1 and net_ro = 0.
  - addr 00 returns 64'h1234; afterwards addr 01 reads 0 and net_ro = 1.
- Hold net_si = 1 with net_di = 64'h5555 while the ICB is full: icb stays 64'h1234 (protocol violation ignored).
- Assert reset mid-wait with OCB and ICB both full:
  - net_so and net_ro drop immediately; after release both status registers read 0.
  - No packet is emitted after reset release.
